// File: rtl/mem_responder.sv
// mem_responder: behavioural memory model that serves a dcache port (read/write)
// and an icache port (read only) from one 2^AW x 32-bit word array.
// Every accepted request waits LAT cycles and then gets exactly one access cycle,
// in which the matching wait signal is low.
// The dcache port wins arbitration in IDLE. A transaction in flight is aborted
// when its request drops or its address changes.
//
// Ports:
//   CLK            clock; all state changes on the rising edge
//   nRST           asynchronous active-low reset (clears the FSM and the whole memory)
//   dREN/dWEN      dcache read/write request (both high counts as a write)
//   daddr/dstore   dcache byte address / write data
//   dwait/dload    dcache wait (low only in the access cycle) / read data
//   iREN/iaddr     icache read request / byte address
//   iwait/iload    icache wait (low only in the access cycle) / read data
module mem_responder #(
    parameter int LAT = 2,
    parameter int AW  = 8
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DBUSY = 3'd1;
    localparam logic [2:0] S_DACC  = 3'd2;
    localparam logic [2:0] S_IBUSY = 3'd3;
    localparam logic [2:0] S_IACC  = 3'd4;

    // The last wait-cycle count before the access cycle. Because LAT is at most 15,
    // the counter stops at 14 at most and cannot wrap.
    localparam logic [3:0] C_LAT_M1 = (LAT > 0) ? 4'(LAT - 1) : 4'd0;
    localparam bit         C_NO_WAIT = (LAT == 0);

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_nxt;
    logic [31:0]   r_addr;
    logic [31:0]   w_addr_nxt;
    logic          r_wr;
    logic          w_wr_nxt;
    logic [31:0]   r_mem [0:(1<<AW)-1];

    logic          w_d_req;
    logic          w_d_hold;
    logic          w_i_hold;
    logic          w_d_acc;
    logic          w_i_acc;
    logic          w_mem_we;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rdata;

    // A transaction stays alive only while its requester keeps the same full 32-bit address.
    assign w_d_req  = dREN | dWEN;
    assign w_d_hold = w_d_req && (daddr == r_addr);
    assign w_i_hold = iREN && (iaddr == r_addr);
    assign w_idx    = r_addr[AW+1:2];
    assign w_rdata  = r_mem[w_idx];

    // An access cycle whose request has been withdrawn is an abort cycle, not an access cycle.
    assign w_d_acc  = (r_state == S_DACC) && w_d_hold;
    assign w_i_acc  = (r_state == S_IACC) && w_i_hold;
    assign w_mem_we = w_d_acc && r_wr;

    assign dwait = ~w_d_acc;
    assign iwait = ~w_i_acc;
    assign dload = w_d_acc ? w_rdata : 32'd0;
    assign iload = w_i_acc ? w_rdata : 32'd0;

    // Next-state, counter and address-latch logic for the arbitration and latency FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_wr_nxt    = r_wr;
        case (r_state)
            S_IDLE: begin
                if (w_d_req) begin
                    w_addr_nxt  = daddr;
                    w_wr_nxt    = dWEN;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = C_NO_WAIT ? S_DACC : S_DBUSY;
                end else if (iREN) begin
                    w_addr_nxt  = iaddr;
                    w_wr_nxt    = 1'b0;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = C_NO_WAIT ? S_IACC : S_IBUSY;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DBUSY: begin
                if (!w_d_hold) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == C_LAT_M1) begin
                    w_state_nxt = S_DACC;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_IBUSY: begin
                if (!w_i_hold) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == C_LAT_M1) begin
                    w_state_nxt = S_IACC;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_DACC:  w_state_nxt = S_IDLE;
            S_IACC:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state, wait counter and latched transaction registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_wr    <= w_wr_nxt;
        end
    end

    // Word array: cleared by reset, written only at the edge that ends a live dcache write access.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int k = 0; k < (1 << AW); k++) begin
                r_mem[k] <= 32'd0;
            end
        end else if (w_mem_we) begin
            r_mem[w_idx] <= dstore;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic        clk;
    logic        nrst;
    logic        d_ren, d_wen, d_wait, i_ren, i_wait;
    logic [31:0] d_addr, d_store, d_load, i_addr, i_load;
    logic        d0_ren, d0_wen, d0_wait, i0_ren, i0_wait;
    logic [31:0] d0_addr, d0_store, d0_load, i0_addr, i0_load;

    int n_assert = 0;
    int n_fail   = 0;

    mem_responder #(.LAT(2), .AW(8)) u_dut (
        .CLK(clk), .nRST(nrst),
        .dREN(d_ren), .dWEN(d_wen), .daddr(d_addr), .dstore(d_store),
        .dwait(d_wait), .dload(d_load),
        .iREN(i_ren), .iaddr(i_addr), .iwait(i_wait), .iload(i_load)
    );

    mem_responder #(.LAT(0), .AW(8)) u_dut0 (
        .CLK(clk), .nRST(nrst),
        .dREN(d0_ren), .dWEN(d0_wen), .daddr(d0_addr), .dstore(d0_store),
        .dwait(d0_wait), .dload(d0_load),
        .iREN(i0_ren), .iaddr(i0_addr), .iwait(i0_wait), .iload(i0_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the dcache access cycle; n counts cycles since the request was set up.
    task automatic wait_d(output int n, output logic [31:0] data);
        bit done;
        done = 1'b0;
        n    = 0;
        data = 32'd0;
        for (int k = 0; k < 40 && !done; k++) begin
            tick();
            n++;
            if (d_wait === 1'b0) begin
                data = d_load;
                done = 1'b1;
            end
        end
        check1("dwait_low_within_bound", done, 1'b1);
    endtask

    task automatic d_access(input logic ren, input logic wen, input logic [31:0] addr,
                            input logic [31:0] data, output logic [31:0] rd, output int n);
        d_ren = ren; d_wen = wen; d_addr = addr; d_store = data;
        wait_d(n, rd);
        tick();
        d_ren = 1'b0; d_wen = 1'b0;
    endtask

    task automatic i_access(input logic [31:0] addr, output logic [31:0] rd, output int n);
        bit done;
        done = 1'b0;
        n  = 0;
        rd = 32'd0;
        i_ren = 1'b1; i_addr = addr;
        for (int k = 0; k < 40 && !done; k++) begin
            tick();
            n++;
            if (i_wait === 1'b0) begin
                rd = i_load;
                done = 1'b1;
            end
        end
        check1("iwait_low_within_bound", done, 1'b1);
        tick();
        i_ren = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          n;
        logic        exp_w [4];
        int          fd, fi;
        logic [31:0] dl, il;
        bit          saw_low;

        nrst = 1'b0;
        d_ren = 1'b0; d_wen = 1'b0; d_addr = 32'd0; d_store = 32'd0;
        i_ren = 1'b0; i_addr = 32'd0;
        d0_ren = 1'b0; d0_wen = 1'b0; d0_addr = 32'd0; d0_store = 32'd0;
        i0_ren = 1'b0; i0_addr = 32'd0;

        // Reset values
        tick(); tick();
        check1("rst_dwait", d_wait, 1'b1);
        check1("rst_iwait", i_wait, 1'b1);
        check32("rst_dload", d_load, 32'd0);
        check32("rst_iload", i_load, 32'd0);
        nrst = 1'b1;
        tick();

        // Held write at 0x40: dwait low only in the 3rd cycle after acceptance
        exp_w = '{1'b1, 1'b1, 1'b0, 1'b1};
        d_wen = 1'b1; d_addr = 32'h40; d_store = 32'hDEADBEEF;
        for (int c = 0; c < 4; c++) begin
            tick();
            check1("wr40_dwait_cycle", d_wait, exp_w[c]);
        end
        d_wen = 1'b0;
        d_access(1'b1, 1'b0, 32'h40, 32'd0, rd, n);
        check32("rd40_data", rd, 32'hDEADBEEF);
        check32("rd40_latency", 32'(n), 32'd3);

        // Simultaneous dcache 0x80 / icache 0x00: dcache first, then icache
        fd = 0; fi = 0; dl = 32'hFFFFFFFF; il = 32'hFFFFFFFF;
        d_ren = 1'b1; d_addr = 32'h80; i_ren = 1'b1; i_addr = 32'h0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (d_wait === 1'b0 && fd == 0) begin
                fd = c; dl = d_load; d_ren = 1'b0;
            end
            if (i_wait === 1'b0 && fi == 0) begin
                fi = c; il = i_load; i_ren = 1'b0;
            end
        end
        check32("arb_dacc_cycle", 32'(fd), 32'd3);
        check32("arb_iacc_cycle", 32'(fi), 32'd7);
        check32("arb_dload_unwritten", dl, 32'd0);
        check32("arb_iload_unwritten", il, 32'd0);

        // dREN+dWEN together is a write; aliasing of upper and low address bits
        d_access(1'b1, 1'b1, 32'h44, 32'h0CADF00D, rd, n);
        check32("both_latency", 32'(n), 32'd3);
        d_access(1'b1, 1'b0, 32'h44, 32'd0, rd, n);
        check32("rd44_data", rd, 32'h0CADF00D);
        d_access(1'b1, 1'b0, 32'h444, 32'd0, rd, n);
        check32("rd444_alias", rd, 32'h0CADF00D);
        d_access(1'b1, 1'b0, 32'hFFFFF047, 32'd0, rd, n);
        check32("rdfff047_alias", rd, 32'h0CADF00D);
        i_access(32'h44, rd, n);
        check32("irs44_data", rd, 32'h0CADF00D);
        check32("irs44_latency", 32'(n), 32'd3);
        check32("iload_idle_zero", i_load, 32'd0);
        check32("dload_idle_zero", d_load, 32'd0);

        // Abort: write to 0x10 dropped during the wait
        d_wen = 1'b1; d_addr = 32'h10; d_store = 32'h12345678;
        tick();
        check1("abort_dbusy_dwait", d_wait, 1'b1);
        d_wen = 1'b0;
        saw_low = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (d_wait !== 1'b1) saw_low = 1'b1;
        end
        check1("abort_never_low", saw_low, 1'b0);
        d_access(1'b1, 1'b0, 32'h10, 32'd0, rd, n);
        check32("abort_rd10", rd, 32'd0);

        // Abort: address changed mid-wait restarts with full latency
        d_ren = 1'b1; d_addr = 32'h40;
        tick();
        check1("chg_dbusy_dwait", d_wait, 1'b1);
        d_addr = 32'h44;
        wait_d(n, rd);
        tick();
        d_ren = 1'b0;
        check32("chg_latency", 32'(n), 32'd4);
        check32("chg_data", rd, 32'h0CADF00D);

        // Abort in the access cycle of a write: no write, dwait goes high at once
        d_wen = 1'b1; d_addr = 32'h50; d_store = 32'h11112222;
        wait_d(n, rd);
        d_wen = 1'b0;
        #1;
        check1("dacc_abort_dwait", d_wait, 1'b1);
        check32("dacc_abort_dload", d_load, 32'd0);
        tick();
        d_access(1'b1, 1'b0, 32'h50, 32'd0, rd, n);
        check32("dacc_abort_rd50", rd, 32'd0);

        // Reset during the wait of a write to 0x20
        d_wen = 1'b1; d_addr = 32'h20; d_store = 32'hA5A5A5A5;
        tick();
        nrst = 1'b0;
        #1;
        check1("midrst_dwait", d_wait, 1'b1);
        check1("midrst_iwait", i_wait, 1'b1);
        check32("midrst_dload", d_load, 32'd0);
        check32("midrst_iload", i_load, 32'd0);
        d_wen = 1'b0;
        tick(); tick();
        nrst = 1'b1;
        tick();
        d_access(1'b1, 1'b0, 32'h20, 32'd0, rd, n);
        check32("midrst_rd20", rd, 32'd0);
        check32("midrst_latency", 32'(n), 32'd3);
        d_access(1'b1, 1'b0, 32'h44, 32'd0, rd, n);
        check32("midrst_mem_cleared", rd, 32'd0);

        // LAT=0 instance: held read alternates IDLE / DACC
        d0_ren = 1'b1; d0_addr = 32'h8;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check1("lat0_dwait_alt", d0_wait, (c % 2 == 0) ? 1'b1 : 1'b0);
        end
        d0_ren = 1'b0;
        d0_wen = 1'b1; d0_store = 32'h600DF00D;
        tick();
        check1("lat0_wr_dwait", d0_wait, 1'b0);
        tick();
        d0_wen = 1'b0; d0_ren = 1'b1;
        tick();
        check1("lat0_rd_dwait", d0_wait, 1'b0);
        check32("lat0_rd_data", d0_load, 32'h600DF00D);
        d0_ren = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LAT, default 2, meaning wait cycles inserted before the access cycle (legal 0..15).
REQ-002 SHALL have parameter AW, default 8, meaning word-address width (memory depth 2^AW 32-bit words).
REQ-003 SHALL have port CLK  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port dREN  input  1  dcache read request.
REQ-006 SHALL have port dWEN  input  1  dcache write request.
REQ-007 SHALL have port daddr  input  32  dcache byte address.
REQ-008 SHALL have port dstore  input  32  dcache write data.
REQ-009 SHALL have port dwait  output  1  low exactly in the dcache access cycle, high otherwise.
REQ-010 SHALL have port dload  output  32  dcache read data, valid when dwait low on a read.
REQ-011 SHALL have port iREN  input  1  icache read request.
REQ-012 SHALL have port iaddr  input  32  icache byte address.
REQ-013 SHALL have port iwait  output  1  low exactly in the icache access cycle, high otherwise.
REQ-014 SHALL have port iload  output  32  icache read data, valid when iwait low.

Function
REQ-015 SHALL index memory with addr[AW+1:2]; upper bits and bits [1:0] ignored (aliasing permitted).
REQ-016 SHALL implement FSM states IDLE, DBUSY, DACC, IBUSY, IACC.
REQ-017 IDLE: dREN|dWEN SHALL latch daddr, op and clear counter, then go DBUSY (LAT>0) or DACC (LAT=0); else iREN SHALL latch iaddr and go IBUSY or IACC likewise; else stay.
REQ-018 Dcache SHALL win when dcache and icache requests are both present in IDLE; no preemption of an in-flight icache transaction.
REQ-019 DBUSY/IBUSY SHALL increment the counter each cycle and go to the ACC state when counter reaches LAT-1.
REQ-020 Latency: a request first sampled in IDLE at edge t SHALL see its wait signal low in cycle t+LAT+1.
REQ-021 DACC: dwait SHALL be 0, dload SHALL equal mem[index] combinationally; a write SHALL update mem[index]=dstore at the edge ending DACC; then IDLE.
REQ-022 IACC: iwait SHALL be 0, iload = mem[index]; then IDLE; the icache SHALL never write.
REQ-023 dREN and dWEN both high SHALL be treated as a write.
REQ-024 Abort: in DBUSY/DACC, if dREN|dWEN is low or daddr differs from the latched address, the FSM SHALL return to IDLE with no write and dwait high; the same rule SHALL apply to iREN/iaddr in IBUSY/IACC.
REQ-025 An abort cycle SHALL not be an access cycle; a changed request is re-arbitrated from IDLE next cycle.
REQ-026 Back-to-back: a request held after its ACC cycle SHALL be re-accepted in the following IDLE cycle (minimum one idle cycle between accesses).
REQ-027 dload/iload SHALL be 0 outside their ACC states.
REQ-028 The counter SHALL be 4 bits and never wrap within a transaction.

Reset
REQ-029 nRST low SHALL asynchronously force state IDLE, counter 0, latched addresses 0, all memory words 0.
REQ-030 During reset, outputs SHALL be dwait=1, iwait=1, dload=0, iload=0.
REQ-031 Reset asserted mid-transaction SHALL discard it with no memory write; after release the FSM SHALL start in IDLE.

Verification
REQ-032 LAT=2: dWEN=1, daddr=0x40, dstore=0xDEADBEEF held -> dwait low in 3rd cycle after acceptance only; later dREN at 0x40 -> dload=0xDEADBEEF while dwait=0.
REQ-033 dREN at 0x80 and iREN at 0x00 asserted in the same cycle -> dcache access completes first, then icache; iload=0 when iwait low (unwritten word).
REQ-034 dREN and dWEN both high at 0x44 with dstore=0xCADF00D -> treated as write; subsequent read of 0x44 returns 0x0CADF00D; aliasing check: read of 0x44+(4<<AW) returns same word.
REQ-035 Abort: dWEN at 0x10 dropped during DBUSY -> dwait never low, read of 0x10 returns 0; daddr changed mid-wait -> FSM restarts, full LAT latency for new address.
REQ-036 nRST pulsed low during DBUSY of a write to 0x20 -> outputs at reset values immediately, read of 0x20 after release returns 0.
REQ-037 LAT=0: held dREN -> dwait low every second cycle (IDLE/DACC alternation).
